// File: rtl/mem_arbiter_if.sv
// Read/write/addr/data/ready handshake bundle shared by the CPU data port,
// the second requester and the shared data-side bus.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  // master issues the request; slave answers with rdata/ready
  modport master (output read, write, addr, wdata, input  rdata, ready);
  modport slave  (input  read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared data-side bus (IDLE/BUSY/DONE).
// Define ARB_TIMEOUT_EN to add the BUSY watchdog and the sticky bus_err flag.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       m0,
  mem_arbiter_if.slave       m1,
  mem_arbiter_if.master      s,
  output logic [1:0]         grant,
  output logic               bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  logic [1:0]    r_state;
  logic          r_rr;      // 1: m1 wins the next tie
  logic          r_owner;   // 0: m0, 1: m1
  logic [1:0]    r_grant;
  logic          r_s_read;
  logic          r_s_write;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_wdata;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_m0_ready;
  logic          r_m1_ready;

  logic          w_req0;
  logic          w_req1;
  logic          w_pick1;
  logic          w_wr;
  logic          w_rd;
  logic          w_timeout;
  logic          w_complete;
  logic [DW-1:0] w_rdata_in;

  assign w_req0     = m0.read | m0.write;
  assign w_req1     = m1.read | m1.write;
  assign w_pick1    = w_req1 & (~w_req0 | r_rr);
  assign w_wr       = w_pick1 ? m1.write : m0.write;
  assign w_rd       = w_pick1 ? m1.read  : m0.read;
  assign w_complete = (r_state == S_BUSY) & (s.ready | w_timeout);

`ifdef ARB_TIMEOUT_EN
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF);

  logic [CW-1:0] r_cnt;
  logic          r_bus_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == S_BUSY) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
      // a real s_ready on the timeout edge wins, so no error is flagged
      if (w_complete && !s.ready) r_bus_err <= 1'b1;
    end
  end

  assign w_timeout  = (r_cnt == CNT_LAST);
  assign w_rdata_in = s.ready ? s.rdata : ERR_DATA;
  assign bus_err    = r_bus_err;
`else
  assign w_timeout  = 1'b0;
  assign w_rdata_in = s.rdata;
  assign bus_err    = 1'b0;
`endif

  // NOTE: the async reset clears the strobes the instant rst rises, which is
  // what aborts an in-flight transaction without a ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr       <= 1'b0;
      r_owner    <= 1'b0;
      r_grant    <= 2'b00;
      r_s_read   <= 1'b0;
      r_s_write  <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req0 || w_req1) begin
            r_owner   <= w_pick1;
            r_grant   <= w_pick1 ? 2'b10 : 2'b01;
            r_s_addr  <= w_pick1 ? m1.addr  : m0.addr;
            r_s_wdata <= w_pick1 ? m1.wdata : m0.wdata;
            r_s_write <= w_wr;
            r_s_read  <= w_rd & ~w_wr;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_complete) begin
            r_s_read  <= 1'b0;
            r_s_write <= 1'b0;
            if (r_s_read) begin
              if (r_owner) r_m1_rdata <= w_rdata_in;
              else         r_m0_rdata <= w_rdata_in;
            end
            if (r_owner) r_m1_ready <= 1'b1;
            else         r_m0_ready <= 1'b1;
            r_rr    <= ~r_owner;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_grant    <= 2'b00;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.read   = r_s_read;
  assign s.write  = r_s_write;
  assign s.addr   = r_s_addr;
  assign s.wdata  = r_s_wdata;
  assign m0.rdata = r_m0_rdata;
  assign m0.ready = r_m0_ready;
  assign m1.rdata = r_m1_rdata;
  assign m1.ready = r_m1_ready;
  assign grant    = r_grant;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter that shares the single data-side bus (data memory plus IO bus and peripherals such as the LED block) between the CPU data port (m0) and a second requester (m1, e.g. a DMA or debug loader).
- Each master uses the read/write/addr/data/ready handshake the CPU already uses.
- The arbiter serialises transactions, applies round-robin fairness and registers all slave-side signals.
- It sits between the CPU data port and the memory/IO decode in the SoC top level.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, cycles in BUSY without s_ready before forced completion (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
m0_read  input  1  master 0 read request, level, held until m0_ready
m0_write  input  1  master 0 write request, level, held until m0_ready
m0_addr  input  AW  master 0 byte address
m0_wdata  input  DW  master 0 write data
m0_rdata  output  DW  master 0 read data, valid while m0_ready=1
m0_ready  output  1  master 0 completion pulse, exactly one cycle
m1_read, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ready  same directions/widths/meaning for master 1
s_read  output  1  read strobe to shared bus
s_write  output  1  write strobe to shared bus
s_addr  output  AW  address to shared bus
s_wdata  output  DW  write data to shared bus
s_rdata  input  DW  read data from shared bus
s_ready  input  1  shared bus completion, sampled at clk edge
grant  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle
bus_err  output  1  sticky timeout flag (ARB_TIMEOUT_EN only, else constant 0)

Behaviour:
- Clocking/reset: single clk. rst asynchronous, active-high; all state updates on rising clk.
- Reset values:
  - All outputs 0.
  - State = IDLE.
  - Round-robin pointer = m0 (m0 wins the first tie).
  - Timeout counter = 0.
- Reset mid-transaction aborts immediately: s_read/s_write drop asynchronously and no ready pulse is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - reqN = mN_read | mN_write.
  - If only one master requests, it wins. If both request, the master not served last wins.
  - At the edge: latch winner's addr, wdata and command into s_addr/s_wdata/s_read/s_write; set grant; go to BUSY.
  - If mN_read and mN_write are both set, the write wins: s_write=1, s_read=0.
  - No request: stay in IDLE, s_* strobes 0, grant=00.
- BUSY:
  - s_* are held stable.
  - Requester inputs are ignored; a master deasserting mid-transaction does not abort it.
  - On the edge where s_ready=1:
    - Clear s_read/s_write.
    - For reads, load s_rdata into the owner's mN_rdata.
    - Assert the owner's mN_ready.
    - Update the round-robin pointer to favour the other master.
    - Go to DONE.
- DONE:
  - One cycle, mN_ready=1; the master must drop its request before the next edge.
  - Next edge: mN_ready=0, grant=00, go to IDLE.
  - mN_rdata holds its value until that master's next read completion. Writes never modify mN_rdata.
- Latency:
  - Request visible in IDLE, then s_* strobe asserted the next cycle.
  - With s_ready=1 in the first BUSY cycle, mN_ready is high in the third cycle.
  - Minimum 3 cycles per transaction, no overlap.
- The non-granted master sees mN_ready=0 and its requests are held pending, never dropped.
- s_addr/s_wdata keep their last values when idle; only the strobes are cleared.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A counter runs in BUSY, cleared on entry to BUSY.
  - When it reaches TIMEOUT with no s_ready, the arbiter completes the transaction as if s_ready=1, with read data 32'hDEADBEEF.
  - bus_err is set; it is sticky until rst.
  - An s_ready arriving on the same edge as the timeout takes precedence: real data, bus_err not set.
- Undefined: no counter; BUSY waits for s_ready indefinitely; bus_err tied to 0.

Test Plan:
- Single read: m0_read=1, addr=0x10; s_ready=1 in first BUSY cycle with s_rdata=0x12345678 -> s_read high one cycle, grant=01, m0_ready pulses one cycle in 3rd cycle, m0_rdata=0x12345678.
- Single write: m1_write=1, addr=0x80000000, wdata=0xFF -> s_write=1, s_addr/s_wdata match, grant=10, m1_ready pulses, m1_rdata unchanged.
- Contention fairness: m0 and m1 request continuously from reset, each re-requesting right after DONE -> grants alternate m0, m1, m0, m1 over 4 transactions; no master starves.
- Wait states: s_ready held low 5 cycles -> s_* stable for all 5 BUSY cycles, single m0_ready pulse after s_ready, no second pulse.
- Reset mid-BUSY: rst asserted while s_read=1 -> s_read=0 and grant=00 without waiting for clk, no mN_ready; after release, a pending m1 request is served.
- ARB_TIMEOUT_EN, s_ready never asserted -> after 16 BUSY cycles, m0_ready pulses with m0_rdata=0xDEADBEEF and bus_err=1, which stays 1 through later good transactions until rst.
